score_packer: RTL
=================

SCORE_PACKER -- requirements
Module: score_packer

Interface
REQ-001 SHALL have parameter NUM_SIZE, default 26, meaning the signed width of one class score.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, meaning the number of class scores per frame.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port GlobalReset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port InValid  in  1  InScore carries a valid score this cycle.
REQ-006 SHALL have port InReady  out  1  block can accept a score this cycle.
REQ-007 SHALL have port InScore  in  NUM_SIZE  signed class score, two's complement.
REQ-008 SHALL have port InLast  in  1  marks the final score of a frame.
REQ-009 SHALL have port Num  out  NUM_SIZE*NUM_CLASSES  packed frame; class k at bits [NUM_SIZE*k +: NUM_SIZE].
REQ-010 SHALL have port OutValid  out  1  Num holds a complete frame for the argmax stage.
REQ-011 SHALL have port OutReady  in  1  argmax stage has consumed Num.
REQ-012 SHALL have port FrameError  out  1  current held frame was malformed.

Function
REQ-013 SHALL implement a two-state FSM: FILL (collecting) and HOLD (presenting).
REQ-014 SHALL drive InReady=1 only in FILL with GlobalReset low; InReady=0 in HOLD.
REQ-015 SHALL accept a score when InValid and InReady are both 1 in the same cycle; InScore is written to slot cnt, then cnt increments.
REQ-016 SHALL use a 4-bit slot counter cnt, range 0..NUM_CLASSES-1; it never wraps past NUM_CLASSES-1.
REQ-017 SHALL move FILL->HOLD on the accept at cnt=NUM_CLASSES-1, regardless of InLast; OutValid=1 from the next cycle.
REQ-018 SHALL, on an accept with InLast=1 and cnt<NUM_CLASSES-1, fill slots cnt+1..NUM_CLASSES-1 with MIN_SCORE (-2^(NUM_SIZE-1)) in that same edge, move to HOLD, and set FrameError=1.
REQ-019 SHALL set FrameError=1 when the accept at cnt=NUM_CLASSES-1 has InLast=0; the frame is still presented.
REQ-020 SHALL hold Num, OutValid=1 and FrameError stable in HOLD until OutReady=1.
REQ-021 SHALL, in HOLD with OutReady=1, return to FILL on that edge with cnt=0, OutValid=0 and FrameError=0; Num keeps its old contents until overwritten.
REQ-022 SHALL never accept a score in the cycle OutReady is sampled: the earliest new accept is the cycle after the return to FILL. Handoff therefore costs a one-cycle bubble.
REQ-023 SHALL ignore OutReady in FILL and InValid in HOLD, with no state change.
REQ-024 SHALL pass scores bit-exact, with no saturation or rescaling.
REQ-025 SHALL have a latency of one cycle from the final accept to OutValid=1; throughput is one frame per NUM_CLASSES+1 cycles.

Reset
REQ-026 SHALL, while GlobalReset=1, force state=FILL, cnt=0, Num=0, OutValid=0, FrameError=0 and InReady=0, asynchronously.
REQ-027 SHALL discard any partial frame when reset is asserted mid-frame or in HOLD; no output frame results.
REQ-028 SHALL resume accepting on the first rising edge after GlobalReset deasserts.

Structure
REQ-029 SHALL place NUM_SIZE, NUM_CLASSES, MIN_SCORE and the FILL/HOLD state encoding in the shared classifier package, also used by the argmax stage.
REQ-030 SHALL be a single module with no sub-module; the slot bank is an indexed register array inside it.
REQ-031 SHALL connect Num directly to the Num input of the argmax stage, with no glue logic.

Verification
REQ-032 SHALL cover: 10 back-to-back accepts with scores 0..9, InLast on the 10th -> OutValid=1 next cycle, slot k=k, FrameError=0.
REQ-033 SHALL cover: scores -5,100,-2^25,3,7,0,0,1,2,99 then OutReady=1 -> FILL next cycle, InReady=1 one cycle later, a new frame accepted correctly.
REQ-034 SHALL cover: InLast on the 4th score (values 1,2,3,4) -> slots 4..9=-33554432, FrameError=1, OutValid=1.
REQ-035 SHALL cover: 10 scores with InLast=0 throughout -> HOLD with FrameError=1; an 11th InValid is not accepted (InReady=0).
REQ-036 SHALL cover: GlobalReset pulsed asynchronously after 5 accepts -> Num=0, cnt=0, OutValid=0 immediately; the next 10 scores form a clean frame.
REQ-037 SHALL cover: OutReady held low for 20 cycles in HOLD while InValid toggles -> Num unchanged and no accepts.

Source files
------------

// File: rtl/score_packer_pkg.sv
// Shared classifier package.
// Holds the default frame geometry (score width, class count), the most
// negative score used to pad short frames, and the FILL/HOLD state encoding.
// The argmax stage imports the same package so both sides agree on the
// frame layout.
package score_packer_pkg;

  // Signed width of one class score.
  localparam int NUM_SIZE    = 26;
  // Number of class scores per frame.
  localparam int NUM_CLASSES = 10;

  // -2^(NUM_SIZE-1). Padding with this value means a padded slot can never
  // win an argmax against a slot that holds a real score.
  localparam logic signed [NUM_SIZE-1:0] MIN_SCORE = {1'b1, {(NUM_SIZE-1){1'b0}}};

  // FILL: collecting scores. HOLD: presenting a complete frame downstream.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/score_packer.sv
// score_packer
// Collects a stream of signed class scores into one packed frame and
// presents it to the argmax stage.
//
// Ports
//   clk          sole clock, rising edge
//   GlobalReset  asynchronous active-high reset
//   InValid      InScore carries a score this cycle
//   InReady      block can accept a score this cycle (FILL and not in reset)
//   InScore      signed class score, two's complement
//   InLast       final score of a frame
//   Num          packed frame; class k at [NUM_SIZE*k +: NUM_SIZE]
//   OutValid     Num holds a complete frame
//   OutReady     downstream has consumed Num
//   FrameError   held frame was malformed (early InLast, or missing InLast)
module score_packer #(
  parameter int NUM_SIZE    = score_packer_pkg::NUM_SIZE,
  parameter int NUM_CLASSES = score_packer_pkg::NUM_CLASSES
) (
  input  logic                            clk,
  input  logic                            GlobalReset,
  input  logic                            InValid,
  output logic                            InReady,
  input  logic [NUM_SIZE-1:0]             InScore,
  input  logic                            InLast,
  output logic [NUM_SIZE*NUM_CLASSES-1:0] Num,
  output logic                            OutValid,
  input  logic                            OutReady,
  output logic                            FrameError
);

  import score_packer_pkg::*;

  localparam logic [3:0] LAST_SLOT = 4'(NUM_CLASSES - 1);
  // Padding value computed at this instance's width so a non-default
  // NUM_SIZE still pads with its own most negative value.
  localparam logic [NUM_SIZE-1:0] PAD_SCORE = {1'b1, {(NUM_SIZE-1){1'b0}}};

  pack_state_t         state, state_next;
  logic [3:0]          cnt, cnt_next;
  logic                frame_error, frame_error_next;
  logic                accept;
  logic                at_last_slot;
  logic                frame_done;

  // Slot bank: one register per class score.
  logic [NUM_SIZE-1:0] slot [NUM_CLASSES];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state       <= FILL;
      cnt         <= '0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      frame_error <= frame_error_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    frame_error_next = frame_error;
    InReady          = 1'b0;
    OutValid         = 1'b0;
    accept           = 1'b0;
    frame_done       = 1'b0;
    at_last_slot     = (cnt == LAST_SLOT);

    if (state == FILL) begin
      // InReady is gated by reset directly so it drops the instant reset
      // rises, not one edge later.
      InReady = !GlobalReset;
      accept  = InValid && !GlobalReset;
      if (accept) begin
        // A frame ends on the last slot or on an early InLast, whichever
        // comes first; the counter therefore never passes LAST_SLOT.
        frame_done = at_last_slot || InLast;
        if (frame_done) begin
          state_next       = HOLD;
          cnt_next         = '0;
          // Well-formed only when InLast coincides exactly with the last slot.
          frame_error_next = (at_last_slot != InLast);
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
    end else begin
      OutValid = 1'b1;
      // InReady stays low through the release edge, so the first new accept
      // is one cycle after returning to FILL.
      if (OutReady) begin
        state_next       = FILL;
        cnt_next         = '0;
        frame_error_next = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot bank write: the addressed slot takes the score; on an early InLast
  // every higher slot is padded in the same edge so the held frame is never
  // partly stale.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        slot[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        if (4'(k) == cnt) begin
          slot[k] <= InScore;
        end else if (InLast && (4'(k) > cnt)) begin
          slot[k] <= PAD_SCORE;
        end
      end
    end
  end

  // Flatten the slot bank onto Num.
  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_pack
      assign Num[NUM_SIZE*gi +: NUM_SIZE] = slot[gi];
    end
  endgenerate

  assign FrameError = frame_error;

endmodule
